// File: rtl/video_dram_sched_pkg.sv
// video_dram_sched_pkg: shared encodings for the DRAM slot scheduler.
//   - video_bw window/need codes and decode helpers
//   - access owner encoding carried through the read-return tag line
//   - scheduler state encoding
package video_dram_sched_pkg;

  // video_bw[4:3] window size codes (2'b10 decodes as 4 slots)
  localparam logic [1:0] BW_2 = 2'b00;
  localparam logic [1:0] BW_4 = 2'b01;
  localparam logic [1:0] BW_8 = 2'b11;

  // video_bw[2:0] one-hot reserved-slot codes
  localparam logic [2:0] NEED_1 = 3'b001;
  localparam logic [2:0] NEED_2 = 3'b010;
  localparam logic [2:0] NEED_4 = 3'b100;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_SHR  = 2'd2
  } state_e;

  typedef struct packed {
    logic   vld;
    owner_e own;
  } rdtag_t;

  function automatic logic [3:0] bw_tot(input logic [1:0] code);
    case (code)
      BW_2:    return 4'd2;
      BW_4:    return 4'd4;
      BW_8:    return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  // Reserved slots can never exceed the window, so clamp to tot.
  function automatic logic [3:0] bw_need(input logic [2:0] code, input logic [3:0] tot);
    logic [3:0] n;
    case (code)
      NEED_1:  n = 4'd1;
      NEED_2:  n = 4'd2;
      NEED_4:  n = 4'd4;
      default: n = 4'd1;
    endcase
    return (n > tot) ? tot : n;
  endfunction

endpackage

// File: rtl/video_dram_sched_if.sv
// video_dram_sched_if: bundle between mode/fetch logic, CPU, DMA and the
// DRAM controller on one side and the slot scheduler on the other.
//   slave  : scheduler view (requests in, DRAM access + acks + strobes out)
//   master : surrounding-logic view
interface video_dram_sched_if;
  logic        slot_stb;
  logic        video_go;
  logic        fetch_stb;
  logic [4:0]  video_bw;
  logic [20:0] video_addr;
  logic        cpu_req;
  logic [20:0] cpu_addr;
  logic        cpu_rnw;
  logic [15:0] cpu_wdata;
  logic        dma_req;
  logic [20:0] dma_addr;
  logic        dma_rnw;
  logic [15:0] dma_wdata;
  logic        dram_req;
  logic [20:0] dram_addr;
  logic        dram_rnw;
  logic [15:0] dram_wdata;
  logic        video_next;
  logic        cpu_ack;
  logic        dma_ack;
  logic        video_strb;
  logic        cpu_strb;
  logic        dma_strb;

  modport slave (
    input  slot_stb, video_go, fetch_stb, video_bw, video_addr,
           cpu_req, cpu_addr, cpu_rnw, cpu_wdata,
           dma_req, dma_addr, dma_rnw, dma_wdata,
    output dram_req, dram_addr, dram_rnw, dram_wdata,
           video_next, cpu_ack, dma_ack, video_strb, cpu_strb, dma_strb
  );

  modport master (
    output slot_stb, video_go, fetch_stb, video_bw, video_addr,
           cpu_req, cpu_addr, cpu_rnw, cpu_wdata,
           dma_req, dma_addr, dma_rnw, dma_wdata,
    input  dram_req, dram_addr, dram_rnw, dram_wdata,
           video_next, cpu_ack, dma_ack, video_strb, cpu_strb, dma_strb
  );
endinterface

// File: rtl/video_dram_rdtag.sv
// video_dram_rdtag: RD_LAT-deep delay line of {valid, owner} read tags.
//   clk, rst_n            : clock, async active-low reset (flushes in-flight tags)
//   i_tag                 : tag of the access on dram_req this clock (vld=read)
//   o_video/cpu/dma_strb  : registered strobes, RD_LAT clocks after i_tag
// The last stage is the decoded strobe register itself, so the tag line is
// RD_LAT-1 deep and the strobes come straight from flops.
module video_dram_rdtag
  import video_dram_sched_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  rdtag_t i_tag,
  output logic   o_video_strb,
  output logic   o_cpu_strb,
  output logic   o_dma_strb
);

  rdtag_t w_tap;
  logic   r_video_strb, r_cpu_strb, r_dma_strb;

  generate
    if (RD_LAT == 1) begin : g_direct
      assign w_tap = i_tag;
    end else begin : g_pipe
      rdtag_t r_tag [RD_LAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RD_LAT-1; i++) r_tag[i] <= '0;
        end else begin
          r_tag[0] <= i_tag;
          for (int i = 1; i < RD_LAT-1; i++) r_tag[i] <= r_tag[i-1];
        end
      end
      assign w_tap = r_tag[RD_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_video_strb <= 1'b0;
      r_cpu_strb   <= 1'b0;
      r_dma_strb   <= 1'b0;
    end else begin
      r_video_strb <= w_tap.vld && (w_tap.own == OWN_VID);
      r_cpu_strb   <= w_tap.vld && (w_tap.own == OWN_CPU);
      r_dma_strb   <= w_tap.vld && (w_tap.own == OWN_DMA);
    end
  end

  assign o_video_strb = r_video_strb;
  assign o_cpu_strb   = r_cpu_strb;
  assign o_dma_strb   = r_dma_strb;

endmodule

// File: rtl/video_dram_sched.sv
// video_dram_sched: DRAM slot scheduler. Each slot_stb is one slot; video
// owns the leading `need` slots of every `tot`-slot window, the rest are
// shared CPU/DMA with DMA anti-starvation. Reads are tagged and returned as
// per-owner strobes RD_LAT clocks after dram_req.
//   clk, rst_n : clock, async active-low reset
//   bus        : video_dram_sched_if.slave (all outputs registered)
module video_dram_sched
  import video_dram_sched_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  video_dram_sched_if.slave bus
);

  localparam int             SW     = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  W_SMAX = SW'(STARVE_MAX);

  state_e        r_state;
  logic [2:0]    r_wcnt;
  logic [3:0]    r_tot, r_need;
  logic [SW-1:0] r_starve;
  logic          r_dram_req, r_dram_rnw;
  logic [20:0]   r_dram_addr;
  logic [15:0]   r_dram_wdata;
  logic          r_video_next, r_cpu_ack, r_dma_ack;
  owner_e        r_owner;

  logic          w_win_start;
  state_e        w_cur_st, w_nxt_st;
  logic [2:0]    w_cur_w, w_nxt_w;
  logic [3:0]    w_cur_tot, w_cur_need, w_w1;
  owner_e        w_gnt;
  logic [SW-1:0] w_nxt_starve;
  rdtag_t        w_tag;

  // Resolve the state this slot is served in: a window start overrides
  // everything (and latches a fresh bw), video_go low drops to shared.
  always_comb begin
    w_win_start = bus.slot_stb & bus.fetch_stb & bus.video_go;
    w_cur_st    = r_state;
    w_cur_w     = r_wcnt;
    w_cur_tot   = r_tot;
    w_cur_need  = r_need;
    if (w_win_start) begin
      w_cur_st   = ST_VID;
      w_cur_w    = 3'd0;
      w_cur_tot  = bw_tot(bus.video_bw[4:3]);
      w_cur_need = bw_need(bus.video_bw[2:0], w_cur_tot);
    end else if (!bus.video_go) begin
      w_cur_st = ST_IDLE;
    end
    w_w1 = {1'b0, w_cur_w} + 4'd1;

    // Window wrap has priority over VID->SHR (covers need == tot).
    if (w_cur_st == ST_IDLE) begin
      w_nxt_st = ST_IDLE;
      w_nxt_w  = 3'd0;
    end else if (w_w1 == w_cur_tot) begin
      w_nxt_st = ST_VID;
      w_nxt_w  = 3'd0;
    end else begin
      w_nxt_w  = w_w1[2:0];
      w_nxt_st = (w_cur_st == ST_VID && w_w1 == w_cur_need) ? ST_SHR : w_cur_st;
    end

    w_gnt        = OWN_NONE;
    w_nxt_starve = r_starve;
    if (w_cur_st == ST_VID) begin
      w_gnt = OWN_VID;
    end else begin
      if (bus.dma_req && (!bus.cpu_req || r_starve == W_SMAX)) w_gnt = OWN_DMA;
      else if (bus.cpu_req)                                    w_gnt = OWN_CPU;
      if (w_gnt == OWN_CPU && bus.dma_req)
        w_nxt_starve = (r_starve == W_SMAX) ? r_starve : r_starve + 1'b1;
      else
        w_nxt_starve = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wcnt       <= '0;
      r_tot        <= '0;
      r_need       <= '0;
      r_starve     <= '0;
      r_dram_req   <= 1'b0;
      r_dram_addr  <= '0;
      r_dram_rnw   <= 1'b0;
      r_dram_wdata <= '0;
      r_video_next <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_owner      <= OWN_NONE;
    end else begin
      // Access outputs are single-clock pulses.
      r_dram_req   <= 1'b0;
      r_dram_addr  <= '0;
      r_dram_rnw   <= 1'b0;
      r_dram_wdata <= '0;
      r_video_next <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_owner      <= OWN_NONE;
      if (bus.slot_stb) begin
        r_state      <= w_nxt_st;
        r_wcnt       <= w_nxt_w;
        r_tot        <= w_cur_tot;
        r_need       <= w_cur_need;
        r_starve     <= w_nxt_starve;
        r_owner      <= w_gnt;
        r_dram_req   <= (w_gnt != OWN_NONE);
        r_video_next <= (w_gnt == OWN_VID);
        r_cpu_ack    <= (w_gnt == OWN_CPU);
        r_dma_ack    <= (w_gnt == OWN_DMA);
        case (w_gnt)
          OWN_VID: begin
            r_dram_addr <= bus.video_addr;
            r_dram_rnw  <= 1'b1;
          end
          OWN_CPU: begin
            r_dram_addr  <= bus.cpu_addr;
            r_dram_rnw   <= bus.cpu_rnw;
            r_dram_wdata <= bus.cpu_wdata;
          end
          OWN_DMA: begin
            r_dram_addr  <= bus.dma_addr;
            r_dram_rnw   <= bus.dma_rnw;
            r_dram_wdata <= bus.dma_wdata;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_tag = '{vld: r_dram_req & r_dram_rnw, own: r_owner};

  video_dram_rdtag #(.RD_LAT(RD_LAT)) u_rdtag (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tag        (w_tag),
    .o_video_strb (bus.video_strb),
    .o_cpu_strb   (bus.cpu_strb),
    .o_dma_strb   (bus.dma_strb)
  );

  assign bus.dram_req   = r_dram_req;
  assign bus.dram_addr  = r_dram_addr;
  assign bus.dram_rnw   = r_dram_rnw;
  assign bus.dram_wdata = r_dram_wdata;
  assign bus.video_next = r_video_next;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.dma_ack    = r_dma_ack;

endmodule

// File: tb/tb_video_dram_sched.sv
// tb_video_dram_sched: directed bench for video_dram_sched. Each step is one
// clock; the expected grant per step is written by hand and the expected
// read strobe is that hand-written grant delayed by LAT steps.
module tb_video_dram_sched;
  import video_dram_sched_pkg::*;

  localparam int          LAT = 2;
  localparam logic [20:0] VA  = 21'h0AAAA;
  localparam logic [20:0] CA  = 21'h12345;
  localparam logic [20:0] DA  = 21'h1BEEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  video_dram_sched_if bus();

  video_dram_sched #(.RD_LAT(LAT), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] hist [LAT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({bus.dram_req, bus.dram_rnw, bus.video_next, bus.cpu_ack,
                            bus.dma_ack, bus.video_strb, bus.cpu_strb, bus.dma_strb}), 32'd0);
    chk({tag, "_addr"}, 32'(bus.dram_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.dram_wdata), 32'd0);
  endtask

  task automatic clr_hist();
    for (int i = 0; i < LAT; i++) hist[i] = 3'b000;
  endtask

  // One clock: check grant issued for the slot sampled at this edge, and the
  // strobe owed by the read issued LAT steps earlier.
  task automatic step(input owner_e own, input logic [20:0] addr,
                      input logic rnw, input logic [15:0] wd);
    logic [3:0] eg;
    logic [2:0] es, ns;
    @(posedge clk); #1;
    case (own)
      OWN_VID: begin eg = 4'b1100; ns = 3'b100; end
      OWN_CPU: begin eg = 4'b1010; ns = 3'b010; end
      OWN_DMA: begin eg = 4'b1001; ns = 3'b001; end
      default: begin eg = 4'b0000; ns = 3'b000; end
    endcase
    if (!rnw) ns = 3'b000;
    es = hist[LAT-1];
    for (int i = LAT-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ns;
    chk("grant", 32'({bus.dram_req, bus.video_next, bus.cpu_ack, bus.dma_ack}), 32'(eg));
    chk("strb", 32'({bus.video_strb, bus.cpu_strb, bus.dma_strb}), 32'(es));
    if (own != OWN_NONE) begin
      chk("addr", 32'(bus.dram_addr), 32'(addr));
      chk("rnw", 32'(bus.dram_rnw), 32'(rnw));
      if (!rnw) chk("wdata", 32'(bus.dram_wdata), 32'(wd));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.slot_stb = 0; bus.video_go = 0; bus.fetch_stb = 0; bus.video_bw = '0;
    bus.video_addr = VA;
    bus.cpu_req = 0; bus.cpu_addr = CA; bus.cpu_rnw = 1; bus.cpu_wdata = 16'h1111;
    bus.dma_req = 0; bus.dma_addr = DA; bus.dma_rnw = 1; bus.dma_wdata = 16'h2222;
    clr_hist();

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk); #1;
    chk_zero("reset_hold");
    rst_n = 1'b1;

    // ZX: 8-slot window, 1 video slot, CPU takes the rest, wrap w/o fetch_stb
    bus.video_bw = 5'b11001; bus.video_go = 1; bus.cpu_req = 1;
    bus.slot_stb = 1; bus.fetch_stb = 1;
    step(OWN_VID, VA, 1, 0);
    bus.fetch_stb = 0;
    for (int i = 0; i < 7; i++) step(OWN_CPU, CA, 1, 0);
    step(OWN_VID, VA, 1, 0);

    // 2-slot window: video/CPU alternate
    bus.video_bw = 5'b00001; bus.fetch_stb = 1;
    step(OWN_VID, VA, 1, 0);
    bus.fetch_stb = 0;
    for (int i = 0; i < 2; i++) begin
      step(OWN_CPU, CA, 1, 0);
      step(OWN_VID, VA, 1, 0);
    end
    step(OWN_CPU, CA, 1, 0);

    // Text: 4 video then 4 DMA, addresses follow each source
    bus.video_bw = 5'b11100; bus.cpu_req = 0; bus.dma_req = 1; bus.fetch_stb = 1;
    step(OWN_VID, VA, 1, 0);
    bus.fetch_stb = 0;
    for (int i = 1; i < 4; i++) begin
      bus.video_addr = VA + 21'(i);
      step(OWN_VID, VA + 21'(i), 1, 0);
    end
    bus.video_addr = VA;
    for (int i = 0; i < 3; i++) step(OWN_DMA, DA, 1, 0);
    bus.dma_rnw = 0; bus.dma_wdata = 16'hD00D;
    step(OWN_DMA, DA, 0, 16'hD00D);
    bus.dma_rnw = 1;

    // video_go low: all shared, DMA wins after 4 CPU grants
    bus.video_go = 0; bus.cpu_req = 1; bus.dma_req = 1;
    step(OWN_CPU, CA, 1, 0);
    bus.cpu_rnw = 0; bus.cpu_wdata = 16'hCAFE;
    step(OWN_CPU, CA, 0, 16'hCAFE);
    bus.cpu_rnw = 1;
    step(OWN_CPU, CA, 1, 0);
    step(OWN_CPU, CA, 1, 0);
    step(OWN_DMA, DA, 1, 0);
    for (int i = 0; i < 4; i++) step(OWN_CPU, CA, 1, 0);
    step(OWN_DMA, DA, 1, 0);
    bus.cpu_req = 0; bus.dma_req = 0;
    step(OWN_NONE, '0, 1, 0);
    bus.slot_stb = 0; bus.cpu_req = 1;
    step(OWN_NONE, '0, 1, 0);
    step(OWN_NONE, '0, 1, 0);

    // fetch_stb at wcnt=5 restarts; bw change at wcnt=3 waits for next window
    bus.slot_stb = 1; bus.video_go = 1; bus.video_bw = 5'b11001;
    bus.cpu_req = 1; bus.dma_req = 0; bus.fetch_stb = 1;
    step(OWN_VID, VA, 1, 0);
    bus.fetch_stb = 0;
    step(OWN_CPU, CA, 1, 0);
    step(OWN_CPU, CA, 1, 0);
    bus.video_bw = 5'b01001;
    step(OWN_CPU, CA, 1, 0);
    step(OWN_CPU, CA, 1, 0);
    bus.slot_stb = 0;
    step(OWN_NONE, '0, 1, 0);
    bus.slot_stb = 1; bus.fetch_stb = 1;
    step(OWN_VID, VA, 1, 0);
    bus.fetch_stb = 0;
    for (int i = 0; i < 3; i++) step(OWN_CPU, CA, 1, 0);
    step(OWN_VID, VA, 1, 0);

    // Async reset mid-window with reads in flight
    step(OWN_CPU, CA, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk); #1;
    chk_zero("rst_flush");
    clr_hist();
    rst_n = 1'b1;
    step(OWN_CPU, CA, 1, 0);
    step(OWN_CPU, CA, 1, 0);
    bus.fetch_stb = 1;
    step(OWN_VID, VA, 1, 0);
    bus.fetch_stb = 0;
    step(OWN_CPU, CA, 1, 0);
    bus.slot_stb = 0; bus.cpu_req = 0;
    step(OWN_NONE, '0, 1, 0);
    step(OWN_NONE, '0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
